// File: rtl/aip_bridge_pkg.sv
// Shared access codes, status/clear bit positions and job-FSM states for the AIP FIFO bridge.
package aip_bridge_pkg;

  localparam int unsigned NET_IN_PUSH = 5'h00;
  localparam int unsigned NET_OUT_POP = 5'h01;
  localparam int unsigned NET_STATUS  = 5'h1E;
  localparam int unsigned NET_ID      = 5'h1F;

  localparam int unsigned UP_IN_POP   = 5'h00;
  localparam int unsigned UP_OUT_PUSH = 5'h01;
  localparam int unsigned UP_STATUS   = 5'h1E;

  localparam int STB_BUSY      = 0;
  localparam int STB_DONE      = 1;
  localparam int STB_IN_EMPTY  = 2;
  localparam int STB_IN_FULL   = 3;
  localparam int STB_OUT_EMPTY = 4;
  localparam int STB_OUT_FULL  = 5;
  localparam int STB_OVF       = 6;
  localparam int STB_UDF       = 7;
  localparam int STB_IN_CNT    = 8;
  localparam int STB_OUT_CNT   = 16;

  localparam int CLR_DONE  = 0;
  localparam int CLR_FLAGS = 1;
  localparam int CLR_FLUSH = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } job_state_t;

endpackage

// File: rtl/aip_sync_fifo.sv
// Single-clock FIFO with flush; rdata shows the head combinationally (0 when empty).
// Push to full is dropped unless a pop happens the same cycle; over/underflow attempts are reported.
module aip_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = empty ? '0 : r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign w_do_push = push && (!full || pop) && !flush;
  assign w_do_pop  = pop && !empty;
  assign ovf       = push && full && !pop;
  assign udf       = pop && empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/aip_fifo_bridge.sv
// AIP net port <-> uP register port bridge with in/out FIFOs, start/done job FSM and status word.
// Reads return one cycle after the strobe; full/empty FIFOs drop/underflow and set sticky flags.
module aip_fifo_bridge
  import aip_bridge_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          CONF_W = 5,
  parameter int          DEPTH  = 16,
  parameter logic [31:0] IP_ID  = 32'h0000_A1F0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CONF_W-1:0] conf_dbus,
  input  logic              read,
  input  logic              write,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              int_req,
  input  logic [CONF_W-1:0] up_conf,
  input  logic              up_read,
  input  logic              up_write,
  input  logic [DATA_W-1:0] up_wdata,
  output logic [DATA_W-1:0] up_rdata,
  output logic              up_start_irq,
  input  logic              up_done
);

  localparam int CW = $clog2(DEPTH) + 1;

  job_state_t        r_state, w_state_nxt;
  logic              w_start_pulse, r_start_irq;
  logic              r_ovf, r_udf;
  logic [DATA_W-1:0] r_data_out, r_up_rdata, w_status;

  logic              w_net_push, w_net_pop, w_net_stat_wr, w_up_pop, w_up_push;
  logic              w_flush, w_clr_flags;
  logic [DATA_W-1:0] w_in_rdata, w_out_rdata;
  logic [CW-1:0]     w_in_count, w_out_count;
  logic              w_in_full, w_in_empty, w_in_ovf, w_in_udf;
  logic              w_out_full, w_out_empty, w_out_ovf, w_out_udf;

  assign w_net_push    = write && (conf_dbus == CONF_W'(NET_IN_PUSH));
  assign w_net_pop     = read && (conf_dbus == CONF_W'(NET_OUT_POP));
  assign w_net_stat_wr = write && (conf_dbus == CONF_W'(NET_STATUS));
  assign w_up_pop      = up_read && (up_conf == CONF_W'(UP_IN_POP));
  assign w_up_push     = up_write && (up_conf == CONF_W'(UP_OUT_PUSH));
  assign w_flush       = w_net_stat_wr && data_in[CLR_FLUSH];
  assign w_clr_flags   = w_net_stat_wr && data_in[CLR_FLAGS];

  aip_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .rst(rst), .push(w_net_push), .pop(w_up_pop), .flush(w_flush),
    .wdata(data_in), .rdata(w_in_rdata), .count(w_in_count),
    .full(w_in_full), .empty(w_in_empty), .ovf(w_in_ovf), .udf(w_in_udf)
  );

  aip_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .rst(rst), .push(w_up_push), .pop(w_net_pop), .flush(w_flush),
    .wdata(up_wdata), .rdata(w_out_rdata), .count(w_out_count),
    .full(w_out_full), .empty(w_out_empty), .ovf(w_out_ovf), .udf(w_out_udf)
  );

  always_comb begin
    w_status                       = '0;
    w_status[STB_BUSY]             = (r_state == S_BUSY);
    w_status[STB_DONE]             = (r_state == S_DONE);
    w_status[STB_IN_EMPTY]         = w_in_empty;
    w_status[STB_IN_FULL]          = w_in_full;
    w_status[STB_OUT_EMPTY]        = w_out_empty;
    w_status[STB_OUT_FULL]         = w_out_full;
    w_status[STB_OVF]              = r_ovf;
    w_status[STB_UDF]              = r_udf;
    w_status[STB_IN_CNT +: CW]     = w_in_count;
    w_status[STB_OUT_CNT +: CW]    = w_out_count;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_start_pulse = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_state_nxt   = S_BUSY;
        w_start_pulse = 1'b1;
      end
      S_BUSY: if (up_done) w_state_nxt = S_DONE;
      S_DONE: if (w_net_stat_wr && data_in[CLR_DONE]) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_start_irq <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_irq <= w_start_pulse;
      r_ovf       <= (r_ovf && !w_clr_flags) || w_in_ovf || w_out_ovf;
      r_udf       <= (r_udf && !w_clr_flags) || w_in_udf || w_out_udf;
    end
  end

  // Read data is captured only on a strobe and held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= '0;
      r_up_rdata <= '0;
    end else begin
      if (read) begin
        case (conf_dbus)
          CONF_W'(NET_OUT_POP): r_data_out <= w_out_rdata;
          CONF_W'(NET_STATUS):  r_data_out <= w_status;
          CONF_W'(NET_ID):      r_data_out <= DATA_W'(IP_ID);
          default:              r_data_out <= '0;
        endcase
      end
      if (up_read) begin
        case (up_conf)
          CONF_W'(UP_IN_POP): r_up_rdata <= w_in_rdata;
          CONF_W'(UP_STATUS): r_up_rdata <= w_status;
          default:            r_up_rdata <= '0;
        endcase
      end
    end
  end

  assign data_out     = r_data_out;
  assign up_rdata     = r_up_rdata;
  assign up_start_irq = r_start_irq;
  assign int_req      = (r_state == S_DONE);

endmodule

// File: tb/tb_aip_fifo_bridge.sv
// Directed-vector bench for aip_fifo_bridge with hand-computed expected values.
module tb_aip_fifo_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  conf_dbus = '0;
  logic        read = 1'b0, write = 1'b0, start = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        int_req;
  logic [4:0]  up_conf = '0;
  logic        up_read = 1'b0, up_write = 1'b0;
  logic [31:0] up_wdata = '0;
  logic [31:0] up_rdata;
  logic        up_start_irq;
  logic        up_done = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  aip_fifo_bridge #(.DATA_W(32), .CONF_W(5), .DEPTH(16), .IP_ID(32'h0000_A1F0)) dut (
    .clk(clk), .rst(rst), .conf_dbus(conf_dbus), .read(read), .write(write),
    .start(start), .data_in(data_in), .data_out(data_out), .int_req(int_req),
    .up_conf(up_conf), .up_read(up_read), .up_write(up_write), .up_wdata(up_wdata),
    .up_rdata(up_rdata), .up_start_irq(up_start_irq), .up_done(up_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // All tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic net_wr(input logic [4:0] c, input logic [31:0] d);
    conf_dbus = c; data_in = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic net_rd(input logic [4:0] c, output logic [31:0] d);
    conf_dbus = c; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; d = data_out;
  endtask

  task automatic up_wr(input logic [4:0] c, input logic [31:0] d);
    up_conf = c; up_wdata = d; up_write = 1'b1;
    @(posedge clk); #1;
    up_write = 1'b0;
  endtask

  task automatic up_rd(input logic [4:0] c, output logic [31:0] d);
    up_conf = c; up_read = 1'b1;
    @(posedge clk); #1;
    up_read = 1'b0; d = up_rdata;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 32'h0);
    check("rst_up_rdata", up_rdata, 32'h0);
    check("rst_int_req", {31'h0, int_req}, 32'h0);
    check("rst_start_irq", {31'h0, up_start_irq}, 32'h0);
    rst = 1'b0;

    net_rd(5'h1E, rd); check("status_reset", rd, 32'h0000_0014);
    net_rd(5'h1F, rd); check("id_read", rd, 32'h0000_A1F0);
    net_rd(5'h05, rd); check("net_unmapped_read", rd, 32'h0);

    // Fill in-FIFO, then overflow it.
    for (int i = 1; i <= 17; i++) net_wr(5'h00, 32'(i));
    net_rd(5'h1E, rd); check("status_in_full_ovf", rd, 32'h0000_1058);
    for (int i = 1; i <= 16; i++) begin
      up_rd(5'h00, rd); check("in_pop_order", rd, 32'(i));
    end
    up_rd(5'h00, rd); check("in_pop_empty", rd, 32'h0);
    up_rd(5'h1E, rd); check("status_ovf_udf", rd, 32'h0000_00D4);
    net_wr(5'h1E, 32'h2);
    net_rd(5'h1E, rd); check("status_flags_cleared", rd, 32'h0000_0014);

    // Job handshake.
    pulse_start();
    check("start_irq_pulse", {31'h0, up_start_irq}, 32'h1);
    @(posedge clk); #1;
    check("start_irq_one_cycle", {31'h0, up_start_irq}, 32'h0);
    net_rd(5'h1E, rd); check("status_busy", rd, 32'h0000_0015);
    pulse_start();
    check("start_in_busy_no_irq", {31'h0, up_start_irq}, 32'h0);
    up_done = 1'b1;
    @(posedge clk); #1;
    up_done = 1'b0;
    check("int_req_rise", {31'h0, int_req}, 32'h1);
    net_rd(5'h1E, rd); check("status_done", rd, 32'h0000_0016);
    net_wr(5'h1E, 32'h1);
    check("int_req_fall", {31'h0, int_req}, 32'h0);
    net_rd(5'h1E, rd); check("status_idle_again", rd, 32'h0000_0014);

    // Simultaneous push and pop on a full in-FIFO.
    for (int i = 0; i < 16; i++) net_wr(5'h00, 32'h100 + 32'(i));
    conf_dbus = 5'h00; data_in = 32'h200; write = 1'b1;
    up_conf = 5'h00; up_read = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; up_read = 1'b0;
    check("full_pushpop_rdata", up_rdata, 32'h100);
    net_rd(5'h1E, rd); check("full_pushpop_status", rd, 32'h0000_1018);
    for (int i = 1; i < 16; i++) begin
      up_rd(5'h00, rd); check("full_pushpop_order", rd, 32'h100 + 32'(i));
    end
    up_rd(5'h00, rd); check("full_pushpop_appended", rd, 32'h200);

    // Out-FIFO wrap: pre-fill and drain 13 so the next 5 pushes cross the end.
    for (int i = 0; i < 13; i++) up_wr(5'h01, 32'(i));
    for (int i = 0; i < 13; i++) net_rd(5'h01, rd);
    for (int i = 0; i < 5; i++) up_wr(5'h01, 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 5; i++) begin
      net_rd(5'h1E, rd); check("out_count", {24'h0, rd[23:16]}, 32'(5 - i));
      net_rd(5'h01, rd); check("out_pop_wrap", rd, 32'hA5A5_0000 + 32'(i));
    end
    net_rd(5'h1E, rd); check("out_count_zero", rd, 32'h0000_0014);

    // Flush wins over a same-cycle uP push.
    for (int i = 0; i < 3; i++) net_wr(5'h00, 32'h300 + 32'(i));
    net_rd(5'h1E, rd); check("status_in3", rd, 32'h0000_0310);
    conf_dbus = 5'h1E; data_in = 32'h4; write = 1'b1;
    up_conf = 5'h01; up_wdata = 32'hDEAD; up_write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; up_write = 1'b0;
    net_rd(5'h1E, rd); check("status_flushed", rd, 32'h0000_0014);

    // Reset mid-job with data queued.
    pulse_start();
    for (int i = 0; i < 3; i++) net_wr(5'h00, 32'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    net_rd(5'h1E, rd); check("status_after_reset", rd, 32'h0000_0014);
    check("int_req_after_reset", {31'h0, int_req}, 32'h0);
    pulse_start();
    check("start_after_reset", {31'h0, up_start_irq}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
